sme_host: RTL and testbench

Stimulus/response front end for the string-matching engine. It buffers one string (up to 32 characters) and one pattern (up to 8 characters) loaded from a local write port. On `start` it streams them over the engine's `chardata`/`isstring`/`ispattern` interface, waits for `valid`, and captures `match`/`match_index` into result registers. It sits between a host or sequencer and the engine, acting as the transmitter end of the engine's input protocol and the receiver end of its result protocol.

---
 rtl/sme_host.sv | 153 +++++++++++++++
 tb/tb_sme_host.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sme_host.sv
// sme_host: buffers one string and one pattern, streams them to the string-matching engine and captures its result.
module sme_host #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic       load_sel,
    input  logic [7:0] load_data,
    input  logic       load_clr,
    input  logic       start,
    input  logic       keep_str,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       timeout,
    output logic       result_match,
    output logic [4:0] result_index,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index
);
    localparam int SW = $clog2(STR_MAX + 1);
    localparam int PW = $clog2(PAT_MAX + 1);
    localparam int SA = $clog2(STR_MAX);
    localparam int PA = $clog2(PAT_MAX);
    localparam logic [SW-1:0] SMAX = SW'(STR_MAX);
    localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);
    localparam logic [9:0] TLAST = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND_S, SEND_P, WAIT, FIN} state_t;

    state_t state;
    logic [7:0] sbuf [STR_MAX];
    logic [7:0] pbuf [PAT_MAX];
    logic [SW-1:0] slen, idx;
    logic [PW-1:0] plen;
    logic [9:0] wcnt;
    logic wr;

    assign wr = reset && state == IDLE && !load_clr && load_en;

    // Buffer contents survive reset; only the lengths are cleared.
    always_ff @(posedge clk) begin
        if (wr && !load_sel && slen != SMAX) sbuf[slen[SA-1:0]] <= load_data;
        if (wr && load_sel && plen != PMAX) pbuf[plen[PA-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            slen <= '0;
            plen <= '0;
            idx <= '0;
            wcnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            timeout <= 1'b0;
            result_match <= 1'b0;
            result_index <= '0;
            chardata <= 8'h00;
            isstring <= 1'b0;
            ispattern <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_clr) begin
                        slen <= '0;
                        plen <= '0;
                    end else if (load_en) begin
                        if (!load_sel && slen != SMAX) slen <= slen + 1'b1;
                        if (load_sel && plen != PMAX) plen <= plen + 1'b1;
                    end
                    if (start) begin
                        if (plen == '0) begin
                            done <= 1'b1;
                            err <= 1'b1;
                            timeout <= 1'b0;
                            state <= FIN;
                        end else if (keep_str || slen == '0) begin
                            busy <= 1'b1;
                            ispattern <= 1'b1;
                            chardata <= pbuf[0];
                            idx <= SW'(1);
                            state <= SEND_P;
                        end else begin
                            busy <= 1'b1;
                            isstring <= 1'b1;
                            chardata <= sbuf[0];
                            idx <= SW'(1);
                            state <= SEND_S;
                        end
                    end
                end
                // The pattern must follow the string with no idle gap.
                SEND_S: begin
                    if (idx == slen) begin
                        isstring <= 1'b0;
                        ispattern <= 1'b1;
                        chardata <= pbuf[0];
                        idx <= SW'(1);
                        state <= SEND_P;
                    end else begin
                        chardata <= sbuf[idx[SA-1:0]];
                        idx <= idx + 1'b1;
                    end
                end
                SEND_P: begin
                    if (idx == SW'(plen)) begin
                        ispattern <= 1'b0;
                        chardata <= 8'h00;
                        wcnt <= '0;
                        state <= WAIT;
                    end else begin
                        chardata <= pbuf[idx[PA-1:0]];
                        idx <= idx + 1'b1;
                    end
                end
                WAIT: begin
                    if (valid) begin
                        result_match <= match;
                        result_index <= match_index;
                        err <= 1'b0;
                        timeout <= 1'b0;
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= FIN;
                    end else if (wcnt == TLAST) begin
                        result_match <= 1'b0;
                        err <= 1'b0;
                        timeout <= 1'b1;
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= FIN;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                FIN: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sme_host.sv
// tb_sme_host: directed test of sme_host with a hand-driven engine response.
module tb_sme_host;
    logic clk = 1'b0, reset = 1'b0;
    logic load_en = 1'b0, load_sel = 1'b0, load_clr = 1'b0, start = 1'b0, keep_str = 1'b0;
    logic valid = 1'b0, match = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic [4:0] match_index = 5'd0;
    logic busy, done, err, timeout, result_match, isstring, ispattern;
    logic [4:0] result_index;
    logic [7:0] chardata;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    sme_host dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
        .load_clr(load_clr), .start(start), .keep_str(keep_str), .busy(busy), .done(done),
        .err(err), .timeout(timeout), .result_match(result_match), .result_index(result_index),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern), .valid(valid),
        .match(match), .match_index(match_index)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input string s);
        load_sel = sel;
        load_en = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            load_data = s[i];
            tick;
        end
        load_en = 1'b0;
    endtask

    task automatic clr;
        load_clr = 1'b1;
        tick;
        load_clr = 1'b0;
    endtask

    task automatic launch(input logic ks);
        keep_str = ks;
        start = 1'b1;
        tick;
        start = 1'b0;
        keep_str = 1'b0;
    endtask

    // Follows the strobes from T+1 and leaves the bench in the first WAIT cycle.
    task automatic stream(input string es, input string ep);
        int ns = 0, np = 0, n = 0;
        check("busy_t1", busy, 1);
        while ((isstring || ispattern) && n < 80) begin
            check("one_strobe", isstring && ispattern, 0);
            if (isstring) begin
                check("str_char", chardata, es[ns]);
                check("str_before_pat", np, 0);
                ns++;
            end
            if (ispattern) begin
                check("pat_char", chardata, ep[np]);
                np++;
            end
            tick;
            n++;
        end
        check("str_cycles", ns, es.len());
        check("pat_cycles", np, ep.len());
        check("wait_chardata", chardata, 0);
        check("wait_busy", busy, 1);
        check("wait_done", done, 0);
    endtask

    task automatic respond(input logic m, input logic [4:0] ix, input int dly);
        repeat (dly) tick;
        valid = 1'b1;
        match = m;
        match_index = ix;
        tick;
        valid = 1'b0;
        match = 1'b0;
        match_index = 5'd0;
        check("done", done, 1);
        check("res_match", result_match, m);
        check("res_index", result_index, ix);
        check("err_clear", err, 0);
        check("to_clear", timeout, 0);
        check("busy_done", busy, 0);
        tick;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        string es, ep;
        int n;
        repeat (2) tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_to", timeout, 0);
        check("rst_match", result_match, 0);
        check("rst_index", result_index, 0);
        check("rst_cd", chardata, 0);
        check("rst_strb", {isstring, ispattern}, 0);
        reset = 1'b1;
        tick;

        load(1'b0, "hello world");
        load(1'b1, "wor");
        launch(1'b0);
        stream("hello world", "wor");
        respond(1'b1, 5'd6, 2);

        valid = 1'b1;
        match_index = 5'd3;
        tick;
        valid = 1'b0;
        match_index = 5'd0;
        check("stray_valid_done", done, 0);
        check("stray_valid_idx", result_index, 6);

        clr;
        load(1'b1, "^hel");
        launch(1'b1);
        stream("", "^hel");
        n = 0;
        while (!done && n < 1100) begin
            tick;
            n++;
        end
        check("to_cycles", n, 1023);
        check("to_flag", timeout, 1);
        check("to_match", result_match, 0);
        check("to_index_kept", result_index, 6);
        tick;

        launch(1'b1);
        stream("", "^hel");
        respond(1'b1, 5'd0, 1);

        clr;
        launch(1'b0);
        check("err_done", done, 1);
        check("err_flag", err, 1);
        check("err_strb", {isstring, ispattern}, 0);
        check("err_busy", busy, 0);
        tick;
        check("err_done_pulse", done, 0);
        check("err_busy_after", busy, 0);

        load(1'b1, "ab");
        launch(1'b0);
        stream("", "ab");
        respond(1'b0, 5'h1f, 1);

        clr;
        es = "";
        ep = "";
        load_sel = 1'b0;
        load_en = 1'b1;
        for (int i = 0; i < 34; i++) begin
            load_data = 8'h41 + 8'(i);
            if (i < 32) es = $sformatf("%s%c", es, load_data);
            tick;
        end
        load_sel = 1'b1;
        for (int i = 0; i < 9; i++) begin
            load_data = 8'h30 + 8'(i);
            if (i < 8) ep = $sformatf("%s%c", ep, load_data);
            tick;
        end
        load_en = 1'b0;
        launch(1'b0);
        stream(es, ep);
        respond(1'b1, 5'd17, 0);

        clr;
        load(1'b0, "abcdefgh");
        load(1'b1, "xy");
        launch(1'b0);
        tick;
        tick;
        check("mid_isstring", isstring, 1);
        check("mid_char", chardata, "c");
        reset = 1'b0;
        tick;
        check("mid_rst_strb", {isstring, ispattern}, 0);
        check("mid_rst_cd", chardata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_res", {result_match, result_index}, 0);
        reset = 1'b1;
        launch(1'b0);
        check("post_rst_err", err, 1);
        check("post_rst_done", done, 1);
        check("post_rst_strb", {isstring, ispattern}, 0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
